// File: rtl/chip8_fetch_unit.sv
// Chip-8 instruction fetch front-end: reads two program bytes, presents the opcode
// over valid/ready, and owns the program counter (advance, skip, jump).
module chip8_fetch_unit #(
  parameter int                    ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] PC_RESET   = ADDR_WIDTH'(12'h200)
) (
  input  logic                  cpu_clk,
  input  logic                  reset_n,
  input  logic                  fetch_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [7:0]            mem_readdata,
  output logic [15:0]           instruction,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [ADDR_WIDTH-1:0] pc,
  input  logic                  pc_skip,
  input  logic                  pc_load,
  input  logic [ADDR_WIDTH-1:0] pc_load_addr
);

  typedef enum logic [2:0] {
    IDLE,
    REQ_HI,
    REQ_LO,
    CAP_LO,
    VALID
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]           instr_q, instr_d;
  logic                  valid_q, valid_d;
  logic                  accept;

  assign accept      = valid_q & instr_ready;
  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;

  always_ff @(posedge cpu_clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= PC_RESET;
      instr_q <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    mem_rd   = 1'b0;
    mem_addr = pc_q;
    case (state_q)
      REQ_HI: mem_rd = 1'b1;
      REQ_LO: begin
        mem_rd   = 1'b1;
        mem_addr = pc_q + ADDR_WIDTH'(1);
      end
      default: ;
    endcase
  end

  // A jump aborts whatever is in progress, including a presented but unaccepted opcode.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (pc_load) begin
      pc_d    = pc_load_addr;
      valid_d = 1'b0;
      state_d = fetch_en ? REQ_HI : IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (fetch_en) state_d = REQ_HI;
        end
        REQ_HI: state_d = REQ_LO;
        REQ_LO: begin
          instr_d[15:8] = mem_readdata;
          state_d       = CAP_LO;
        end
        CAP_LO: begin
          instr_d[7:0] = mem_readdata;
          valid_d      = 1'b1;
          state_d      = VALID;
        end
        VALID: begin
          if (accept) begin
            valid_d = 1'b0;
            pc_d    = pc_q + (pc_skip ? ADDR_WIDTH'(4) : ADDR_WIDTH'(2));
            state_d = fetch_en ? REQ_HI : IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
